wb_grf_unit: RTL and testbench
==============================

WB_GRF_UNIT -- requirements
Module: wb_grf_unit

Interface
REQ-001 SHALL have: clk  in  1  clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high; clock clk.
REQ-003 SHALL have: W_instruction  in  32  instruction in write-back stage; 0x00000000 = bubble/nop.
REQ-004 SHALL have: W_pc  in  32  PC of W_instruction.
REQ-005 SHALL have: W_ans  in  32  ALU result carried to W.
REQ-006 SHALL have: W_Rdata  in  32  data-memory load result carried to W.
REQ-007 SHALL have: D_rs_addr, D_rt_addr  in  5 each  decode-stage read addresses.
REQ-008 SHALL have: D_rs_data, D_rt_data  out  32 each  read data for D_rs_addr / D_rt_addr.
REQ-009 SHALL have: W_we  out  1  write enable for the current W instruction, for hazard/forwarding logic.
REQ-010 SHALL have: W_waddr  out  5  destination register; W_wdata  out  32  write-back value.
REQ-011 SHALL have: retire_cnt  out  32  count of non-bubble instructions retired.

Function
REQ-012 SHALL decode opcode = W_instruction[31:26], funct = [5:0], rt = [20:16], rd = [15:11].
REQ-013 SHALL for opcode 0x00 with funct 0x20 (add) or 0x22 (sub): dest rd, data W_ans.
REQ-014 SHALL for opcode 0x0D (ori) or 0x0F (lui): dest rt, data W_ans.
REQ-015 SHALL for opcode 0x23 (lw): dest rt, data W_Rdata.
REQ-016 SHALL for opcode 0x03 (jal): dest 31, data W_pc + 8 (32-bit, wraps modulo 2^32).
REQ-017 SHALL treat all other encodings (sw, beq, jr, nop, other R-type, unknown) as no write: W_we=0, W_waddr=0, W_wdata=0.
REQ-018 SHALL force W_we=0 when decoded dest is 0; W_waddr/W_wdata still show decoded values.
REQ-019 W_we, W_waddr, W_wdata SHALL be combinational from W_* inputs (zero latency).
REQ-020 SHALL hold a 32x32 register file; entry 0 reads 0 always and is never written.
REQ-021 SHALL write W_wdata into entry W_waddr on rising edge when W_we=1 and rst=0; new value visible from the following cycle.
REQ-022 D_rs_data/D_rt_data SHALL be combinational reads; address 0 returns 0.
REQ-023 Both read ports SHALL operate independently; identical addresses return identical data.
REQ-024 retire_cnt SHALL increment by 1 on each rising edge where rst=0 and W_instruction != 0, including non-writing instructions.
REQ-025 retire_cnt SHALL wrap 0xFFFFFFFF -> 0x00000000 without flag.

Reset
REQ-026 On rising edge with rst=1: all 32 entries <= 0, retire_cnt <= 0.
REQ-027 rst SHALL take priority over a simultaneous write and count; that cycle's W instruction is discarded.
REQ-028 Reset mid-program SHALL need exactly one cycle; normal operation resumes next edge.

Configuration
REQ-029 Macro GRF_BYPASS_EN SHALL control internal write-to-read bypass.
REQ-030 With GRF_BYPASS_EN defined: if W_we=1 and read address == W_waddr (nonzero), that port returns W_wdata same cycle.
REQ-031 Without GRF_BYPASS_EN: read ports return stored entry only; same-cycle write visible next cycle.

Verification
REQ-032 rst=1 one cycle, then D_rs_addr=5 -> D_rs_data=0, retire_cnt=0.
REQ-033 ori rt=8, W_ans=0x00001234 -> same cycle W_we=1, W_waddr=8; next cycle D_rt_addr=8 reads 0x00001234; retire_cnt=1.
REQ-034 lw rt=9, W_Rdata=0xDEADBEEF, W_ans=0x10 -> entry 9 = 0xDEADBEEF.
REQ-035 jal at W_pc=0x00003000 -> entry 31 = 0x00003008; bubble 0x0 next cycle -> retire_cnt unchanged.
REQ-036 add rd=0, W_ans=0xFFFFFFFF -> W_we=0, entry 0 reads 0; sw -> W_we=0, no entry changes, retire_cnt +1.
REQ-037 entry 8 = 0x1234, ori rt=8 W_ans=0x55 with D_rs_addr=8 same cycle -> 0x55 if GRF_BYPASS_EN, else 0x1234; both 0x55 next cycle.

Source files
------------

// File: rtl/wb_grf_unit_if.sv
// Write-back / decode-read bus of the GRF unit: W-stage instruction inputs, decode read ports, write-back observation.
// The master drives W_* inputs and read addresses; the slave (the unit) returns read data and write-back info.
interface wb_grf_unit_if;
  logic [31:0] W_instruction;
  logic [31:0] W_pc;
  logic [31:0] W_ans;
  logic [31:0] W_Rdata;
  logic [4:0]  D_rs_addr;
  logic [4:0]  D_rt_addr;
  logic [31:0] D_rs_data;
  logic [31:0] D_rt_data;
  logic        W_we;
  logic [4:0]  W_waddr;
  logic [31:0] W_wdata;
  logic [31:0] retire_cnt;

  modport master (
    output W_instruction, W_pc, W_ans, W_Rdata, D_rs_addr, D_rt_addr,
    input  D_rs_data, D_rt_data, W_we, W_waddr, W_wdata, retire_cnt
  );

  modport slave (
    input  W_instruction, W_pc, W_ans, W_Rdata, D_rs_addr, D_rt_addr,
    output D_rs_data, D_rt_data, W_we, W_waddr, W_wdata, retire_cnt
  );
endinterface

// File: rtl/wb_grf_unit.sv
// Write-back decode, 32x32 register file with two combinational read ports, and retired-instruction counter.
// Optional macro GRF_BYPASS_EN forwards the same-cycle write-back value onto matching read ports.
module wb_grf_unit (
  input  logic           clk,
  input  logic           rst,
  wb_grf_unit_if.slave   bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        wr_hit;
  logic [4:0]  dest;
  logic [31:0] data;
  logic        we;

  logic [31:0] rf_q [32];
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  assign opcode = bus.W_instruction[31:26];
  assign funct  = bus.W_instruction[5:0];
  assign rt     = bus.W_instruction[20:16];
  assign rd     = bus.W_instruction[15:11];

  // rs and shamt fields play no part in write-back selection
  logic unused_fields;
  assign unused_fields = ^{bus.W_instruction[25:21], bus.W_instruction[10:6]};

  always_comb begin
    wr_hit = 1'b0;
    dest   = 5'd0;
    data   = 32'd0;
    unique case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADD || funct == FN_SUB) begin
          wr_hit = 1'b1;
          dest   = rd;
          data   = bus.W_ans;
        end
      end
      OP_ORI, OP_LUI: begin
        wr_hit = 1'b1;
        dest   = rt;
        data   = bus.W_ans;
      end
      OP_LW: begin
        wr_hit = 1'b1;
        dest   = rt;
        data   = bus.W_Rdata;
      end
      OP_JAL: begin
        wr_hit = 1'b1;
        dest   = 5'd31;
        data   = bus.W_pc + 32'd8;
      end
      default: begin
        wr_hit = 1'b0;
      end
    endcase
  end

  // A write to $0 still reports its decoded address/data but never commits
  assign we          = wr_hit && (dest != 5'd0);
  assign bus.W_we    = we;
  assign bus.W_waddr = dest;
  assign bus.W_wdata = data;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else if (we) begin
      rf_q[dest] <= data;
    end
  end

  function automatic logic [31:0] read_port(input logic [4:0] addr);
    logic [31:0] val;
    val = (addr == 5'd0) ? 32'd0 : rf_q[addr];
`ifdef GRF_BYPASS_EN
    if (we && addr == dest) begin
      val = data;
    end
`endif
    return val;
  endfunction

  assign bus.D_rs_data = read_port(bus.D_rs_addr);
  assign bus.D_rt_data = read_port(bus.D_rt_addr);

  always_comb begin
    cnt_d = cnt_q;
    if (bus.W_instruction != 32'd0) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_grf_unit.sv
// Scoreboard bench for wb_grf_unit: driver pushes model-predicted outputs per cycle, monitor pops and compares at negedge.
// Reference model is an array-based architectural register file plus a retire counter.
module tb_wb_grf_unit;

  logic clk;
  logic rst;
  wb_grf_unit_if bus ();

  wb_grf_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_rf [32];
  logic [31:0] m_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  // Architectural write-back semantics: which register an instruction targets and with what value
  function automatic void ref_wb(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] ans,
                                 input logic [31:0] rdat, output logic we, output logic [4:0] a,
                                 output logic [31:0] d);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    a  = 5'd0;
    d  = 32'd0;
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) begin
      a = ins[15:11]; d = ans;
    end else if (op == 6'h0D || op == 6'h0F) begin
      a = ins[20:16]; d = ans;
    end else if (op == 6'h23) begin
      a = ins[20:16]; d = rdat;
    end else if (op == 6'h03) begin
      a = 5'd31; d = pc + 32'd8;
    end
    we = (a != 5'd0);
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] addr, input logic we, input logic [4:0] wa,
                                           input logic [31:0] wd);
    logic [31:0] v;
    v = (addr == 5'd0) ? 32'd0 : m_rf[addr];
`ifdef GRF_BYPASS_EN
    if (we && addr == wa) v = wd;
`else
    if (we && wa == 5'd0 && wd == 32'd1) v = v; // keeps arguments referenced in both builds
`endif
    return v;
  endfunction

  task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] ans,
                      input logic [31:0] rdat, input logic [4:0] rsa, input logic [4:0] rta);
    exp_t e;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    rst               = r;
    bus.W_instruction = ins;
    bus.W_pc          = pc;
    bus.W_ans         = ans;
    bus.W_Rdata       = rdat;
    bus.D_rs_addr     = rsa;
    bus.D_rt_addr     = rta;
    ref_wb(ins, pc, ans, rdat, we, wa, wd);
    e.idx   = cyc;
    e.we    = we;
    e.waddr = wa;
    e.wdata = wd;
    e.rs    = ref_read(rsa, we, wa, wd);
    e.rt    = ref_read(rta, we, wa, wd);
    e.cnt   = m_cnt;
    sb_q.push_back(e);
    if (r) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_cnt = 32'd0;
    end else begin
      if (we) m_rf[wa] = wd;
      if (ins != 32'd0) m_cnt = m_cnt + 32'd1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] rdf, input logic [5:0] fn);
    logic [31:0] v;
    v = {6'h00, 5'($urandom), 5'($urandom), rdf, 5'd0, fn};
    return v;
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rtf);
    logic [31:0] v;
    v = {op, 5'($urandom), rtf, 16'($urandom)};
    return v;
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] v;
    logic [4:0]  r;
    r = 5'($urandom);
    case ($urandom_range(0, 11))
      0:  v = mk_r(r, 6'h20);
      1:  v = mk_r(r, 6'h22);
      2:  v = mk_i(6'h0D, r);
      3:  v = mk_i(6'h0F, r);
      4:  v = mk_i(6'h23, r);
      5:  v = {6'h03, 26'($urandom)};
      6:  v = mk_i(6'h2B, r);
      7:  v = mk_i(6'h04, r);
      8:  v = mk_r(r, 6'h08);
      9:  v = mk_r(r, 6'($urandom));
      10: v = 32'd0;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("W_we",       e.idx, {31'd0, bus.W_we}, {31'd0, e.we});
        check("W_waddr",    e.idx, {27'd0, bus.W_waddr}, {27'd0, e.waddr});
        check("W_wdata",    e.idx, bus.W_wdata, e.wdata);
        check("D_rs_data",  e.idx, bus.D_rs_data, e.rs);
        check("D_rt_data",  e.idx, bus.D_rt_data, e.rt);
        check("retire_cnt", e.idx, bus.retire_cnt, e.cnt);
      end
    end
  end

  initial begin : driver
    int drain;
    rst               = 1'b1;
    bus.W_instruction = 32'd0;
    bus.W_pc          = 32'd0;
    bus.W_ans         = 32'd0;
    bus.W_Rdata       = 32'd0;
    bus.D_rs_addr     = 5'd0;
    bus.D_rt_addr     = 5'd0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_cnt = 32'd0;
    @(posedge clk);
    #1;

    // Directed sequence covering the documented scenarios
    step(0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0);
    step(0, {6'h0D, 5'd0, 5'd8, 16'h1234}, 32'h100, 32'h0000_1234, 32'h0, 5'd8, 5'd0);
    step(0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd8);
    step(0, {6'h23, 5'd2, 5'd9, 16'h0010}, 32'h104, 32'h10, 32'hDEAD_BEEF, 5'd9, 5'd8);
    step(0, {6'h03, 26'h0000C00}, 32'h0000_3000, 32'h0, 32'h0, 5'd9, 5'd31);
    step(0, 32'd0, 32'h3004, 32'h0, 32'h0, 5'd9, 5'd31);
    step(0, {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20}, 32'h108, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0);
    step(0, {6'h2B, 5'd0, 5'd8, 16'h0004}, 32'h10C, 32'h4, 32'h7777_7777, 5'd8, 5'd9);
    step(0, {6'h0D, 5'd0, 5'd8, 16'h0055}, 32'h110, 32'h55, 32'h0, 5'd8, 5'd31);
    step(0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd8, 5'd8);
    step(1, {6'h0D, 5'd0, 5'd3, 16'h00AA}, 32'h114, 32'hAA, 32'h0, 5'd3, 5'd8);
    step(0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd3, 5'd8);
    step(0, mk_r(5'd31, 6'h22), 32'h118, 32'hCAFE_F00D, 32'h0, 5'd31, 5'd31);
    step(0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd31, 5'd31);

    // Randomized traffic with occasional mid-program resets
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 49) == 0), rand_ins(), $urandom, $urandom, $urandom,
           5'($urandom), 5'($urandom));
    end
    step(0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);

    drain = 0;
    while (sb_q.size() > 0 && drain < 4) begin
      @(negedge clk);
      drain++;
    end
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
